bcd_updown_counter: RTL

//   Multi-digit BCD up/down event counter; upstream stage of the 7-seg decode/shift-out block.
//   - Synchronises and edge-detects an external count input.
//   - Maintains a DIGITS-wide packed BCD value and presents it as cnt_out.
//   - Issues rate-limited trigger pulses so the downstream decode/shift cycle is never re-triggered mid-cycle.

---
 rtl/bcd_cnt_pkg.sv | 17 +
 rtl/bcd_digit.sv | 48 ++++
 rtl/bcd_updown_counter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared constants, trigger FSM state type and BCD helpers for the BCD up/down counter.
package bcd_cnt_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } trig_state_e;

  // Non-decimal nibbles (A-F) saturate to 9 so the count always holds valid BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with increment/decrement and carry/borrow ripple to the next digit.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic             carry_out,
  output logic             borrow_out,
  output logic [BCD_W-1:0] digit_d_o,
  output logic [BCD_W-1:0] digit_q_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  assign carry_out  = carry_in  && (digit_q == BCD_MAX);
  assign borrow_out = borrow_in && (digit_q == '0);

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (carry_in) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + BCD_W'(1);
    end else if (borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_d_o = digit_d;
  assign digit_q_o = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down event counter with rate-limited display trigger.
// Optional pin debouncer enabled by defining CNT_DEBOUNCE_EN.
module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS          = 6,
  parameter int TRIG_HOLDOFF    = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cnt_pin,
  input  logic                    dir,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    refresh,
  output logic [BCD_W*DIGITS-1:0] cnt_out,
  output logic                    trigger,
  output logic                    ovf,
  output logic                    unf
);

  localparam int CNT_W = BCD_W * DIGITS;
  localparam int HO_W  = $clog2(TRIG_HOLDOFF + 1);

  generate
    if (TRIG_HOLDOFF < 4 * DIGITS + 8 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("bcd_updown_counter: TRIG_HOLDOFF or DEBOUNCE_CYCLES out of range");
    end
  endgenerate

  // Input path: 2-flop synchroniser, optional debounce, registered rising-edge strobe.
  logic sync1_q, sync2_q;
  logic lvl, lvl_prev_q, ev_q;

`ifdef CNT_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sync2_q == deb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_q     <= sync2_q;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      ev_q       <= 1'b0;
    end else begin
      sync1_q    <= cnt_pin;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
      ev_q       <= lvl & ~lvl_prev_q;
    end
  end

  // Count datapath: clear/load outrank events, so carry/borrow only start without them.
  logic              up, dn;
  logic [DIGITS:0]   carry, borrow;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  assign up        = ev_q & enable & dir  & ~clear & ~load;
  assign dn        = ev_q & enable & ~dir & ~clear & ~load;
  assign carry[0]  = up;
  assign borrow[0] = dn;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[g*BCD_W +: BCD_W]),
      .carry_in   (carry[g]),
      .borrow_in  (borrow[g]),
      .carry_out  (carry[g+1]),
      .borrow_out (borrow[g+1]),
      .digit_d_o  (cnt_d[g*BCD_W +: BCD_W]),
      .digit_q_o  (cnt_q[g*BCD_W +: BCD_W])
    );
  end

  assign cnt_out = cnt_q;

  // Trigger FSM: pending records "display is stale"; holdoff spaces triggers apart.
  trig_state_e     state_q, state_d;
  logic [HO_W-1:0] holdoff_q, holdoff_d;
  logic            pending_q, pending_d;
  logic            trigger_q, ovf_q, unf_q;
  logic            issue;

  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q && holdoff_q == '0) begin
          issue     = 1'b1;
          holdoff_d = HO_W'(TRIG_HOLDOFF - 1);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (holdoff_q <= HO_W'(1)) begin
          holdoff_d = '0;
          state_d   = IDLE;
        end else begin
          holdoff_d = holdoff_q - HO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_q;
    if (issue) pending_d = 1'b0;
    if ((cnt_d != cnt_q) || refresh) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      holdoff_q <= '0;
      pending_q <= 1'b1;
      trigger_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      pending_q <= pending_d;
      trigger_q <= issue;
      ovf_q     <= carry[DIGITS];
      unf_q     <= borrow[DIGITS];
    end
  end

  assign trigger = trigger_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule
